// File: rtl/nubus_slave_bridge.sv
// NuBus slave bridge: decodes slot/super-slot starts, runs the shared-memory
// handshake and terminates each accepted transfer with a status-coded ACK.
module nubus_slave_bridge #(
   parameter logic [3:0]               SLOTS_ADDRESS  = 4'hF,
   parameter int                       NUM_WINDOWS    = 2,
   parameter logic [8*NUM_WINDOWS-1:0] WIN_MASK       = 16'hF0C0,
   parameter logic [8*NUM_WINDOWS-1:0] WIN_ADDR       = 16'h9000,
   parameter int                       TIMEOUT_CYCLES = 255
) (
   input  logic                   nub_clkn,
   input  logic                   nub_reset,
   input  logic [3:0]             nub_idn,
   input  logic                   nub_startn_i,
   input  logic                   nub_tm1n_i,
   input  logic                   nub_tm0n_i,
   input  logic [31:0]            nub_adn_i,
   output logic [31:0]            nub_adn_o,
   output logic                   nub_ad_oe,
   output logic                   nub_ackn_o,
   output logic                   nub_tm1n_o,
   output logic                   nub_tm0n_o,
   output logic                   nub_ctl_oe,
   output logic                   mem_valid,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_wdata,
   output logic [3:0]             mem_wstrb,
   input  logic                   mem_ready,
   input  logic [31:0]            mem_rdata,
   output logic [NUM_WINDOWS:0]   mem_sel,
   output logic [7:0]             stat_timeouts
);

   typedef enum logic [1:0] {S_IDLE, S_WDATA, S_ACCESS, S_ACK} state_t;

   // Status on {tm1n, tm0n} during ACK
   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_ERR = 2'b10;
   localparam logic [1:0] ST_TO  = 2'b01;
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t               state_q;
   logic                 write_q;
   logic [15:0]          wd_q;
   logic [31:0]          adn_q;
   logic                 ad_oe_q;
   logic                 ackn_q;
   logic [1:0]           stat_q;
   logic                 ctl_oe_q;
   logic                 valid_q;
   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
   logic [3:0]           wstrb_q;
   logic [NUM_WINDOWS:0] sel_q;
   logic [7:0]           tocnt_q;

   logic [31:0]          addr_d;
   logic                 slot_hit_d;
   logic [NUM_WINDOWS:0] sel_d;
   logic                 hit_d;
   logic [3:0]           strb_d;
   logic                 reserved_d;

   assign addr_d     = ~nub_adn_i;
   assign slot_hit_d = (addr_d[31:28] == SLOTS_ADDRESS) && (addr_d[27:24] == ~nub_idn);
   assign hit_d      = |sel_d;

   // Walk windows high to low so the lowest matching index ends up selected; slot space beats all.
   always_comb begin
      sel_d = '0;
      for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
         if ((addr_d[31:24] & WIN_MASK[8*i +: 8]) == WIN_ADDR[8*i +: 8]) begin
            sel_d        = '0;
            sel_d[i + 1] = 1'b1;
         end
      end
      if (slot_hit_d) sel_d = (NUM_WINDOWS + 1)'(1);
   end

   always_comb begin
      strb_d     = 4'b0000;
      reserved_d = 1'b0;
      if (!nub_tm0n_i) begin
         strb_d = 4'b0001 << addr_d[1:0];
      end else begin
         case (addr_d[1:0])
            2'b00:   strb_d = 4'hF;
            2'b01:   strb_d = 4'h3;
            2'b11:   strb_d = 4'hC;
            default: reserved_d = 1'b1;
         endcase
      end
   end

   always_ff @(negedge nub_clkn or posedge nub_reset) begin
      if (nub_reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         wd_q     <= '0;
         adn_q    <= '1;
         ad_oe_q  <= 1'b0;
         ackn_q   <= 1'b1;
         stat_q   <= 2'b11;
         ctl_oe_q <= 1'b0;
         valid_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         sel_q    <= '0;
         tocnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!nub_startn_i && hit_d) begin
                  addr_q  <= addr_d;
                  sel_q   <= sel_d;
                  write_q <= ~nub_tm1n_i;
                  if (reserved_d) begin
                     wstrb_q  <= '0;
                     ctl_oe_q <= 1'b1;
                     ackn_q   <= 1'b0;
                     stat_q   <= ST_ERR;
                     state_q  <= S_ACK;
                  end else if (!nub_tm1n_i) begin
                     wstrb_q <= strb_d;
                     state_q <= S_WDATA;
                  end else begin
                     wstrb_q <= '0;
                     valid_q <= 1'b1;
                     wd_q    <= '0;
                     state_q <= S_ACCESS;
                  end
               end
            end
            S_WDATA: begin
               wdata_q <= ~nub_adn_i;
               valid_q <= 1'b1;
               wd_q    <= '0;
               state_q <= S_ACCESS;
            end
            S_ACCESS: begin
               wd_q <= wd_q + 16'd1;
               if (mem_ready) begin
                  valid_q  <= 1'b0;
                  ctl_oe_q <= 1'b1;
                  ackn_q   <= 1'b0;
                  stat_q   <= ST_OK;
                  if (!write_q) begin
                     ad_oe_q <= 1'b1;
                     adn_q   <= ~mem_rdata;
                  end
                  state_q <= S_ACK;
               end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
                  valid_q  <= 1'b0;
                  ctl_oe_q <= 1'b1;
                  ackn_q   <= 1'b0;
                  stat_q   <= ST_TO;
                  if (tocnt_q != 8'hFF) tocnt_q <= tocnt_q + 8'd1;
                  state_q <= S_ACK;
               end
            end
            default: begin
               ctl_oe_q <= 1'b0;
               ackn_q   <= 1'b1;
               stat_q   <= 2'b11;
               ad_oe_q  <= 1'b0;
               adn_q    <= '1;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign nub_adn_o     = adn_q;
   assign nub_ad_oe     = ad_oe_q;
   assign nub_ackn_o    = ackn_q;
   assign nub_tm1n_o    = stat_q[1];
   assign nub_tm0n_o    = stat_q[0];
   assign nub_ctl_oe    = ctl_oe_q;
   assign mem_valid     = valid_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wstrb     = wstrb_q;
   assign mem_sel       = sel_q;
   assign stat_timeouts = tocnt_q;

endmodule

// File: tb/tb_nubus_slave_bridge.sv
// Directed bench for nubus_slave_bridge with a short watchdog (4 cycles).
module tb_nubus_slave_bridge;

   logic        nub_clkn = 1'b1;
   logic        nub_reset;
   logic [3:0]  nub_idn;
   logic        nub_startn_i, nub_tm1n_i, nub_tm0n_i;
   logic [31:0] nub_adn_i;
   logic [31:0] nub_adn_o;
   logic        nub_ad_oe, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, nub_ctl_oe;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [2:0]  mem_sel;
   logic [7:0]  stat_timeouts;

   int errors = 0;
   int checks = 0;

   nubus_slave_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .nub_clkn(nub_clkn), .nub_reset(nub_reset), .nub_idn(nub_idn),
      .nub_startn_i(nub_startn_i), .nub_tm1n_i(nub_tm1n_i), .nub_tm0n_i(nub_tm0n_i),
      .nub_adn_i(nub_adn_i), .nub_adn_o(nub_adn_o), .nub_ad_oe(nub_ad_oe),
      .nub_ackn_o(nub_ackn_o), .nub_tm1n_o(nub_tm1n_o), .nub_tm0n_o(nub_tm0n_o),
      .nub_ctl_oe(nub_ctl_oe), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .mem_sel(mem_sel), .stat_timeouts(stat_timeouts)
   );

   always #5 nub_clkn = ~nub_clkn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next falling edge.
   task automatic edge_();
      @(negedge nub_clkn);
      #1;
   endtask

   task automatic bus_idle();
      nub_startn_i = 1'b1;
      nub_tm1n_i   = 1'b1;
      nub_tm0n_i   = 1'b1;
      nub_adn_i    = '1;
   endtask

   task automatic do_start(input logic [31:0] a, input logic tm1n, input logic tm0n);
      nub_startn_i = 1'b0;
      nub_adn_i    = ~a;
      nub_tm1n_i   = tm1n;
      nub_tm0n_i   = tm0n;
      edge_();
      bus_idle();
   endtask

   task automatic chk_ack(input string tag, input logic [1:0] st);
      chk({tag, "_ctl_oe"}, {31'd0, nub_ctl_oe}, 32'd1);
      chk({tag, "_ackn"}, {31'd0, nub_ackn_o}, 32'd0);
      chk({tag, "_status"}, {30'd0, nub_tm1n_o, nub_tm0n_o}, {30'd0, st});
      chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd0);
   endtask

   task automatic timeout_txn();
      do_start(32'hF500_0020, 1'b1, 1'b1);
      repeat (4) edge_();
      edge_();
   endtask

   initial begin
      nub_reset = 1'b1;
      nub_idn   = 4'hA;
      mem_ready = 1'b0;
      mem_rdata = '0;
      bus_idle();
      repeat (2) edge_();
      chk("rst_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_ackn", {31'd0, nub_ackn_o}, 32'd1);
      chk("rst_adn", nub_adn_o, 32'hFFFF_FFFF);
      chk("rst_sel", {29'd0, mem_sel}, 32'd0);
      nub_reset = 1'b0;
      edge_();

      // Slot-space word read
      do_start(32'hF500_0010, 1'b1, 1'b1);
      chk("rd_valid", {31'd0, mem_valid}, 32'd1);
      chk("rd_sel", {29'd0, mem_sel}, 32'b001);
      chk("rd_addr", mem_addr, 32'hF500_0010);
      chk("rd_wstrb", {28'd0, mem_wstrb}, 32'd0);
      chk("rd_noack", {31'd0, nub_ctl_oe}, 32'd0);
      mem_ready = 1'b1;
      mem_rdata = 32'h1234_5678;
      edge_();
      mem_ready = 1'b0;
      chk_ack("rd", 2'b00);
      chk("rd_ad_oe", {31'd0, nub_ad_oe}, 32'd1);
      chk("rd_adn", nub_adn_o, 32'hEDCB_A987);
      edge_();
      chk("rd_release", {31'd0, nub_ctl_oe}, 32'd0);
      chk("rd_ad_oe_off", {31'd0, nub_ad_oe}, 32'd0);

      // Byte write to lane 3
      do_start(32'hF500_0003, 1'b0, 1'b0);
      nub_adn_i = ~32'hAB00_0000;
      chk("wr_wdata_phase_valid", {31'd0, mem_valid}, 32'd0);
      chk("wr_wstrb", {28'd0, mem_wstrb}, 32'b1000);
      edge_();
      bus_idle();
      chk("wr_valid", {31'd0, mem_valid}, 32'd1);
      chk("wr_wdata", mem_wdata, 32'hAB00_0000);
      mem_ready = 1'b1;
      edge_();
      mem_ready = 1'b0;
      chk_ack("wr", 2'b00);
      chk("wr_ad_oe", {31'd0, nub_ad_oe}, 32'd0);
      edge_();

      // Window 1 (mask F0, match 90)
      do_start(32'h9012_0000, 1'b1, 1'b1);
      chk("win1_sel", {29'd0, mem_sel}, 32'b100);
      chk("win1_valid", {31'd0, mem_valid}, 32'd1);
      mem_ready = 1'b1;
      edge_();
      mem_ready = 1'b0;
      chk_ack("win1", 2'b00);
      edge_();

      // Window 0 (mask C0, match 00)
      do_start(32'h3000_0000, 1'b1, 1'b1);
      chk("win0_sel", {29'd0, mem_sel}, 32'b010);
      mem_ready = 1'b1;
      edge_();
      mem_ready = 1'b0;
      chk_ack("win0", 2'b00);
      edge_();

      // Miss: no access, no ACK
      do_start(32'hE500_0000, 1'b1, 1'b1);
      chk("miss_valid", {31'd0, mem_valid}, 32'd0);
      chk("miss_ctl_oe", {31'd0, nub_ctl_oe}, 32'd0);
      edge_();
      chk("miss_ctl_oe2", {31'd0, nub_ctl_oe}, 32'd0);

      // Reserved half-word size: immediate error ACK
      do_start(32'hF500_0012, 1'b1, 1'b1);
      chk_ack("rsv", 2'b10);
      chk("rsv_ad_oe", {31'd0, nub_ad_oe}, 32'd0);
      edge_();
      chk("rsv_release", {31'd0, nub_ctl_oe}, 32'd0);
      chk("rsv_valid2", {31'd0, mem_valid}, 32'd0);

      // Watchdog timeout after 4 cycles
      do_start(32'hF500_0020, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         edge_();
         chk("to_wait_valid", {31'd0, mem_valid}, 32'd1);
         chk("to_wait_noack", {31'd0, nub_ctl_oe}, 32'd0);
      end
      edge_();
      chk_ack("to", 2'b01);
      chk("to_count1", {24'd0, stat_timeouts}, 32'd1);
      edge_();

      // mem_ready on the limit edge beats the timeout
      do_start(32'hF500_0020, 1'b1, 1'b1);
      repeat (3) edge_();
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_00FF;
      edge_();
      mem_ready = 1'b0;
      chk_ack("race", 2'b00);
      chk("race_adn", nub_adn_o, 32'hFFFF_FF00);
      chk("race_count", {24'd0, stat_timeouts}, 32'd1);
      edge_();

      // Saturation of the timeout counter
      for (int i = 0; i < 253; i++) timeout_txn();
      chk("to_count_fe", {24'd0, stat_timeouts}, 32'hFE);
      for (int i = 0; i < 46; i++) timeout_txn();
      chk("to_count_sat", {24'd0, stat_timeouts}, 32'hFF);

      // Asynchronous reset during ACCESS
      do_start(32'hF500_0040, 1'b1, 1'b1);
      chk("arst_pre_valid", {31'd0, mem_valid}, 32'd1);
      nub_reset = 1'b1;
      #1;
      chk("arst_valid", {31'd0, mem_valid}, 32'd0);
      chk("arst_addr", mem_addr, 32'd0);
      chk("arst_sel", {29'd0, mem_sel}, 32'd0);
      chk("arst_count", {24'd0, stat_timeouts}, 32'd0);
      chk("arst_ctl", {29'd0, nub_ctl_oe, nub_tm1n_o, nub_tm0n_o}, 32'b011);
      #1;
      nub_reset = 1'b0;
      edge_();
      chk("arst_noack", {31'd0, nub_ctl_oe}, 32'd0);
      do_start(32'hF500_0004, 1'b1, 1'b1);
      chk("post_valid", {31'd0, mem_valid}, 32'd1);
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE_0001;
      edge_();
      mem_ready = 1'b0;
      chk_ack("post", 2'b00);
      chk("post_adn", nub_adn_o, 32'h3501_FFFE);
      edge_();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
